serial_fir_acc: RTL
===================

# serial_fir_acc

Downstream stage of the bit-serial FIR: collects the serial product streams of N_TAPS `trunc_serial_mult` instances (one bit per tap per cycle, LSB first, S(4,3)), deserializes them, sums all taps in full precision, saturates to S(4,3) and presents one parallel output sample per frame through a valid/ready buffer. It shares the frame counter that drives the multipliers.

## Interface
- N_TAPS, 4: number of multiplier streams summed
- NB_DATA, 4: product bits per tap per frame, S(4,3)
- NB_COUNTER, 3: frame counter width (frame = 8 cycles, counter 0..7)
- NB_ACC, NB_DATA+$clog2(N_TAPS) = 6: full-precision sum width, S(6,3)
- clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_en  in  1  global enable, same signal as multipliers
- i_counter  in  NB_COUNTER  shared frame counter
- i_data  in  N_TAPS  serial product bit of tap k on bit k
- o_data  out  NB_DATA  saturated sum, S(4,3), two's complement
- o_valid  out  1  o_data holds an unconsumed sample
- i_ready  in  1  sink accepts o_data when o_valid & i_ready
- o_drop  out  1  one-cycle pulse: completed sample discarded (buffer full)
- o_sat  out  1  registered alongside o_data: this sample was clipped

## Operation
- Reset (i_rst low, any time, mid-frame included): all shift regs, pipeline regs, o_data=0, o_valid=0, o_drop=0, o_sat=0, frame_ok=0.
- Capture window: i_counter 4..7 (bits arrive LSB first). With i_en high, per tap sr_k <= {i_data[k], sr_k[NB_DATA-1:1]}.
- frame_ok: set when i_en & counter==4; cleared on reset and after each frame end. A frame completes only if frame_ok was set, so a frame started before reset release is ignored.
- Stage 1 (edge at i_en & counter==7 & frame_ok): word_k <= {i_data[k], sr_k[3:1]}; w_valid <= 1, else w_valid <= 0.
- Stage 2: sum <= Σ sign-extend(word_k) to NB_ACC bits; s_valid <= w_valid. No overflow possible (range -32..28).
- Stage 3 saturation: sum > 7 -> 0111, sum < -8 -> 1000, else sum[3:0]; sat flag = clipped.
- Output buffer, evaluated each edge with s_valid: if !o_valid or i_ready -> load o_data/o_sat, o_valid <= 1; else discard, o_drop <= 1 for one cycle, o_data unchanged.
- Without a load: o_valid & i_ready -> o_valid <= 0. Simultaneous accept and new load -> load wins, o_valid stays 1.
- i_en low: capture, frame_ok and stages 1-2 hold; the output handshake and stage-3 load keep running (i_en does not gate the buffer).
- i_counter outside 0..7 impossible by width; counter 0..3 cycles do not shift.

## Timing
- Latency: word complete at counter==7 edge (E); sum at E+1; o_valid rises at E+2 (counter==1 of next frame, i_en continuously high).
- Throughput: one sample per 8 cycles; sink has 8 cycles to accept before a drop.
- o_drop asserted in cycle E+2 exactly when the load is refused.
- All outputs registered; no combinational path from i_ready to o_valid/o_data.

## Structure
- Package serial_fir_pkg: NB_DATA, NB_COUNTER, CNT_FIRST=4, CNT_LAST=7, SAT_MAX=4'b0111, SAT_MIN=4'b1000, helper for NB_ACC.
- Sub-module serial_deser (one per tap, generate loop): shift register + stage-1 word register, parameter NB_DATA, inputs clk/i_rst/i_en/shift/load/bit.
- Adder, saturation and output buffer stay in serial_fir_acc.

## Test plan
- Four taps each 0001 (0.125) -> o_data 0100, o_sat 0, o_valid rises 2 cycles after counter==7, i_ready high.
- Taps 0011, 1110, 0001, 1111 (3,-2,1,-1) -> o_data 0001, o_sat 0.
- All taps 0010 (sum 8) -> o_data 0111, o_sat 1; all taps 1000 (sum -32) -> o_data 1000, o_sat 1.
- i_ready low across two frames (0100 then 0001) -> o_data stays 0100, o_drop pulses once at 2nd E+2; i_ready high -> o_valid falls next edge.
- i_rst low at counter==5 released at counter==6 -> outputs 0, that frame produces nothing, next full frame outputs normally.
- i_en low for 3 cycles at counter==5 (counter frozen by sequencer) -> result identical to uninterrupted frame, latency extended by 3 cycles.

Source files
------------

// File: rtl/serial_fir_pkg.sv
// Shared constants for the bit-serial FIR accumulator stage.
// Frame is 8 cycles; product bits arrive on counter 4..7, LSB first.
package serial_fir_pkg;

    localparam int NB_DATA    = 4;
    localparam int NB_COUNTER = 3;

    localparam logic [NB_COUNTER-1:0] CNT_FIRST = 3'd4;
    localparam logic [NB_COUNTER-1:0] CNT_LAST  = 3'd7;

    localparam logic [NB_DATA-1:0] SAT_MAX = 4'b0111;
    localparam logic [NB_DATA-1:0] SAT_MIN = 4'b1000;

    function automatic int acc_width(input int n_taps);
        return NB_DATA + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/serial_deser.sv
// One tap deserializer: LSB-first shift register plus stage-1 word.
// Only the top NB_DATA-1 bits are kept; the last bit goes straight into the word.
module serial_deser #(
    parameter int NB_DATA = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               shift,
    input  logic               load,
    input  logic               sbit,
    output logic [NB_DATA-1:0] word
);

    logic [NB_DATA-2:0] sr;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            sr   <= '0;
            word <= '0;
        end else if (i_en) begin
            if (shift) sr <= {sbit, sr[NB_DATA-2:1]};
            if (load) word <= {sbit, sr};
        end
    end

endmodule

// File: rtl/serial_fir_acc.sv
// Sums N_TAPS serial product streams, saturates to S(4,3) and
// presents one sample per frame through a single-entry valid/ready buffer.
module serial_fir_acc
    import serial_fir_pkg::*;
#(
    parameter int N_TAPS = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [NB_COUNTER-1:0] i_counter,
    input  logic [N_TAPS-1:0]     i_data,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_drop,
    output logic                  o_sat
);

    localparam int NB_ACC = acc_width(N_TAPS);

    logic               shift;
    logic               last;
    logic               frame_ok;
    logic               w_valid;
    logic               s_valid;
    logic               clip_hi;
    logic               clip_lo;
    logic [NB_DATA-1:0] word [N_TAPS];
    logic [NB_ACC-1:0]  acc;
    logic [NB_ACC-1:0]  sum;
    logic [NB_DATA-1:0] sat_data;

    assign shift = (i_counter >= CNT_FIRST);
    assign last  = (i_counter == CNT_LAST) && frame_ok;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        serial_deser #(
            .NB_DATA(NB_DATA)
        ) u_deser (
            .clk  (clk),
            .i_rst(i_rst),
            .i_en (i_en),
            .shift(shift),
            .load (last),
            .sbit (i_data[k]),
            .word (word[k])
        );
    end

    // A frame only counts if its first capture cycle was seen out of reset.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_ok <= 1'b0;
        end else if (i_en) begin
            if (i_counter == CNT_LAST) frame_ok <= 1'b0;
            else if (i_counter == CNT_FIRST) frame_ok <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) w_valid <= 1'b0;
        else w_valid <= i_en & last;
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc = acc + {{(NB_ACC-NB_DATA){word[k][NB_DATA-1]}}, word[k]};
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            sum     <= '0;
            s_valid <= 1'b0;
        end else begin
            s_valid <= w_valid;
            if (w_valid) sum <= acc;
        end
    end

    // In range iff all bits above the S(4,3) sign bit match it.
    assign clip_hi = !sum[NB_ACC-1] && (sum[NB_ACC-2:NB_DATA-1] != '0);
    assign clip_lo = sum[NB_ACC-1] && (sum[NB_ACC-2:NB_DATA-1] != '1);

    always_comb begin
        sat_data = sum[NB_DATA-1:0];
        if (clip_hi) sat_data = SAT_MAX;
        if (clip_lo) sat_data = SAT_MIN;
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_drop  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            if (s_valid) begin
                if (!o_valid || i_ready) begin
                    o_data  <= sat_data;
                    o_sat   <= clip_hi | clip_lo;
                    o_valid <= 1'b1;
                end else begin
                    o_drop <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
